// File: rtl/vector_response_checker_pkg.sv
// ============================================================================
// Module      : vector_response_checker_pkg
// Description : State encodings and truth-table lookup helper shared by the
//               vector response checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vector_response_checker_pkg;

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ARMED    = 2'd1;
    localparam logic [1:0] c_ST_SETTLING = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;

endpackage

// Entry for vector v in a table packed with stride w.
`define VRC_TABLE_ENTRY(tbl, v, w) tbl[(v)*(w) +: (w)]

`default_nettype wire

// File: rtl/vector_response_checker_if.sv
// ============================================================================
// Module      : vector_response_checker_if
// Description : Stimulus/response bundle between a vector source and the
//               response checker, plus the checker's result outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vector_response_checker_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2
);
    logic                   start;
    logic                   vec_valid;
    logic [IN_W-1:0]        vec_in;
    logic [OUT_W-1:0]       resp_in;

    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [IN_W:0]          err_count;
    logic                   first_err_valid;
    logic [IN_W-1:0]        first_err_vec;
    logic [(1<<IN_W)-1:0]   seen_mask;

    modport master (
        output start, vec_valid, vec_in, resp_in,
        input  busy, done, pass, err_count, first_err_valid, first_err_vec, seen_mask
    );

    modport slave (
        input  start, vec_valid, vec_in, resp_in,
        output busy, done, pass, err_count, first_err_valid, first_err_vec, seen_mask
    );

endinterface

`default_nettype wire

// File: rtl/vector_response_checker_settle_timer.sv
// ============================================================================
// Module      : settle_timer
// Description : Loadable saturating counter flagging when a vector has been
//               held stable for SETTLE cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer #(
    parameter int SETTLE = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic load,
    input  wire logic inc,
    input  wire logic clr,
    output wire logic expired
);

    localparam int                 c_CNT_W = $clog2(SETTLE + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(SETTLE);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    // clr beats load beats inc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_ONE;
        end else if (inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign expired = (r_cnt == c_MAX);

endmodule

`default_nettype wire

// File: rtl/vector_response_checker.sv
// ============================================================================
// Module      : vector_response_checker
// Description : Samples a DUT response once its input vector has settled,
//               checks it against a golden table and tracks coverage/errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_response_checker
    import vector_response_checker_pkg::*;
#(
    parameter int                          IN_W     = 3,
    parameter int                          OUT_W    = 2,
    parameter logic [(1<<IN_W)*OUT_W-1:0]  EXPECTED = 16'hE4A1,
    parameter int                          SETTLE   = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    vector_response_checker_if.slave  bus
);

    localparam int                 c_VECS       = 1 << IN_W;
    localparam int                 c_TBL_W      = c_VECS * OUT_W;
    localparam int                 c_IDX_W      = (c_TBL_W > 1) ? $clog2(c_TBL_W) : 1;
    localparam logic [c_IDX_W-1:0] c_OUT_STRIDE = c_IDX_W'(OUT_W);

    logic [1:0]         r_state;
    logic [IN_W-1:0]    r_cur_vec;
    logic               r_sampled;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [IN_W:0]      r_err_count;
    logic               r_first_err_valid;
    logic [IN_W-1:0]    r_first_err_vec;
    logic [c_VECS-1:0]  r_seen_mask;

    logic [1:0]         w_state_nxt;
    logic               w_load;
    logic               w_inc;
    logic               w_clr;
    logic               w_expired;
    logic               w_held;
    logic               w_sample;
    logic               w_first_seen;
    logic               w_mismatch;
    logic               w_count_err;
    logic [c_IDX_W-1:0] w_tbl_v;
    logic [c_VECS-1:0]  w_seen_nxt;
    logic [IN_W:0]      w_err_nxt;

    assign w_held  = bus.vec_valid && (bus.vec_in == r_cur_vec);
    assign w_tbl_v = c_IDX_W'(r_cur_vec);

    // A held vector samples once; start in the same cycle drops the sample.
    assign w_sample     = (r_state == c_ST_SETTLING) && w_held && w_expired &&
                          !r_sampled && !bus.start;
    assign w_first_seen = w_sample && !r_seen_mask[r_cur_vec];
    assign w_mismatch   = (bus.resp_in != `VRC_TABLE_ENTRY(EXPECTED, w_tbl_v, c_OUT_STRIDE));
    assign w_count_err  = w_first_seen && w_mismatch;
    assign w_err_nxt    = r_err_count + {{IN_W{1'b0}}, w_count_err};

    always_comb begin
        w_seen_nxt = r_seen_mask;
        if (w_first_seen) begin
            w_seen_nxt[r_cur_vec] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_clr       = 1'b0;
        if (bus.start) begin
            w_state_nxt = c_ST_ARMED;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                c_ST_ARMED: begin
                    if (bus.vec_valid) begin
                        w_state_nxt = c_ST_SETTLING;
                        w_load      = 1'b1;
                    end
                end
                c_ST_SETTLING: begin
                    if (!bus.vec_valid) begin
                        w_state_nxt = c_ST_ARMED;
                        w_clr       = 1'b1;
                    end else if (!w_held) begin
                        w_load = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                        if (w_first_seen && (&w_seen_nxt)) begin
                            w_state_nxt = c_ST_DONE;
                        end
                    end
                end
                c_ST_IDLE, c_ST_DONE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .inc     (w_inc),
        .clr     (w_clr),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= c_ST_IDLE;
            r_cur_vec         <= '0;
            r_sampled         <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
            r_seen_mask       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == c_ST_ARMED) || (w_state_nxt == c_ST_SETTLING);
            if (bus.start) begin
                r_sampled         <= 1'b0;
                r_done            <= 1'b0;
                r_pass            <= 1'b0;
                r_err_count       <= '0;
                r_first_err_valid <= 1'b0;
                r_first_err_vec   <= '0;
                r_seen_mask       <= '0;
            end else begin
                if (w_load) begin
                    r_cur_vec <= bus.vec_in;
                    r_sampled <= 1'b0;
                end
                if (w_sample) begin
                    r_sampled <= 1'b1;
                end
                if (w_first_seen) begin
                    r_seen_mask <= w_seen_nxt;
                    r_err_count <= w_err_nxt;
                    if (w_mismatch && !r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_vec   <= r_cur_vec;
                    end
                end
                if ((w_state_nxt == c_ST_DONE) && (r_state != c_ST_DONE)) begin
                    r_done <= 1'b1;
                    r_pass <= (w_err_nxt == '0);
                end
            end
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_count       = r_err_count;
    assign bus.first_err_valid = r_first_err_valid;
    assign bus.first_err_vec   = r_first_err_vec;
    assign bus.seen_mask       = r_seen_mask;

endmodule

`default_nettype wire
